// File: rtl/io_rs232_tx.sv
// -----------------------------------------------------------------------------
// io_rs232_tx
//   Host-to-line RS-232 path. Drains one USB OUT endpoint buffer and sends it
//   as 8N1 UART frames on TXD: start 0, d0..d7 LSB first, stop 1. Each bit
//   lasts BAUD_DIV clk. The endpoint is re-armed after every packet, including
//   zero-length packets.
//
//   Optional feature macro: RS232_TX_CTS_EN
//     defined   : the start bit of each frame waits for cts (synchronised) = 1;
//                 once a frame has started it always completes.
//     undefined : cts is ignored and frames start immediately.
//
// Parameters
//   BAUD_DIV  clk cycles per UART bit (2..65535)
//   MAX_LEN   largest packet in bytes; longer buf_out_len values are clamped
//
// Ports
//   clk              in   sole clock
//   reset            in   synchronous active-high reset
//   buf_out_addr     out  [8:0] endpoint buffer read address
//   buf_out_q        in   [7:0] buffer read data, valid 2 clk after addr change
//   buf_out_len      in   [9:0] byte count of pending packet
//   buf_out_hasdata  in   packet pending (async, synchronised here)
//   buf_out_arm      out  1-clk pulse: packet consumed, re-arm endpoint
//   buf_out_arm_ack  in   endpoint acknowledges re-arm (async, synchronised)
//   cts              in   clear-to-send (async, synchronised; CTS build only)
//   txd              out  UART serial output, idle high
//   busy             out  FSM is not idle
//   bytes_sent       out  [15:0] completed frames, wraps silently
// -----------------------------------------------------------------------------
module io_rs232_tx #(
  parameter int BAUD_DIV = 434,
  parameter int MAX_LEN  = 512
) (
  input  logic        clk,
  input  logic        reset,
  output logic [8:0]  buf_out_addr,
  input  logic [7:0]  buf_out_q,
  input  logic [9:0]  buf_out_len,
  input  logic        buf_out_hasdata,
  output logic        buf_out_arm,
  input  logic        buf_out_arm_ack,
  input  logic        cts,
  output logic        txd,
  output logic        busy,
  output logic [15:0] bytes_sent
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [9:0]  MAX_LEN_L = 10'(MAX_LEN);
  localparam logic [3:0]  STOP_IDX  = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LEN, ST_RD_0, ST_RD_1, ST_LOAD,
    ST_SHIFT, ST_NEXT, ST_ARM, ST_ARM_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  len_q, len_d;
  // One bit wider than the port so a full 512-byte packet compares correctly.
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] bytes_q, bytes_d;
  logic        arm_q, arm_d;
  logic        txd_q, txd_d;

  logic [1:0]  hasdata_sync_q;
  logic [1:0]  ack_sync_q;
  logic        hasdata_s;
  logic        arm_ack_s;

`ifdef RS232_TX_CTS_EN
  logic [1:0]  cts_sync_q;
  logic        cts_s;
  // Set once the current frame has been released by cts.
  logic        go_q, go_d;
  assign cts_s = cts_sync_q[1];
`else
  logic        unused_cts;
  assign unused_cts = cts;
`endif

  assign hasdata_s = hasdata_sync_q[1];
  assign arm_ack_s = ack_sync_q[1];

  // Line level for frame bit index 0..9 (0 = start, 1..8 = data, 9 = stop).
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data);
    if (idx == 4'd0)          return 1'b0;
    else if (idx >= STOP_IDX) return 1'b1;
    else                      return data[idx[2:0] - 3'd1];
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    bytes_d = bytes_q;
`ifdef RS232_TX_CTS_EN
    go_d    = go_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (hasdata_s) begin
          len_d   = (buf_out_len > MAX_LEN_L) ? MAX_LEN_L : buf_out_len;
          addr_d  = '0;
          state_d = ST_LEN;
        end
      end
      ST_LEN:  state_d = (len_q == 10'd0) ? ST_ARM : ST_RD_0;
      // Two wait states cover the registered buffer RAM latency.
      ST_RD_0: state_d = ST_RD_1;
      ST_RD_1: state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d = buf_out_q;
        cnt_d   = BIT_LAST;
        bit_d   = 4'd0;
`ifdef RS232_TX_CTS_EN
        go_d    = 1'b0;
`endif
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
`ifdef RS232_TX_CTS_EN
        // Hold the line idle with the bit counter frozen until cts is seen.
        if (!go_q) go_d = cts_s;
        else
`endif
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (bit_q == STOP_IDX) begin
          bytes_d = bytes_q + 16'd1;
          addr_d  = addr_q + 10'd1;
          state_d = ST_NEXT;
        end else begin
          bit_d = bit_q + 4'd1;
          cnt_d = BIT_LAST;
        end
      end
      ST_NEXT:     state_d = (addr_q == len_q) ? ST_ARM : ST_RD_0;
      ST_ARM:      state_d = ST_ARM_WAIT;
      // hasdata is only looked at again after the endpoint acknowledges the
      // re-arm, so a stale hasdata cannot start a second pass over the packet.
      ST_ARM_WAIT: if (arm_ack_s) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state values: glitch-free, no extra lag.
    arm_d = (state_d == ST_ARM);
    txd_d = 1'b1;
`ifdef RS232_TX_CTS_EN
    if (state_d == ST_SHIFT && go_d) txd_d = frame_bit(bit_d, shreg_d);
`else
    if (state_d == ST_SHIFT) txd_d = frame_bit(bit_d, shreg_d);
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    if (reset) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      addr_q         <= '0;
      shreg_q        <= '0;
      cnt_q          <= '0;
      bit_q          <= '0;
      bytes_q        <= '0;
      arm_q          <= 1'b0;
      txd_q          <= 1'b1;
      hasdata_sync_q <= '0;
      ack_sync_q     <= '0;
`ifdef RS232_TX_CTS_EN
      cts_sync_q     <= '0;
      go_q           <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      addr_q         <= addr_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      bytes_q        <= bytes_d;
      arm_q          <= arm_d;
      txd_q          <= txd_d;
      hasdata_sync_q <= {hasdata_sync_q[0], buf_out_hasdata};
      ack_sync_q     <= {ack_sync_q[0], buf_out_arm_ack};
`ifdef RS232_TX_CTS_EN
      cts_sync_q     <= {cts_sync_q[0], cts};
      go_q           <= go_d;
`endif
    end
  end

  assign buf_out_addr = addr_q[8:0];
  assign buf_out_arm  = arm_q;
  assign txd          = txd_q;
  assign busy         = (state_q != ST_IDLE);
  assign bytes_sent   = bytes_q;

endmodule

// File: tb/tb_io_rs232_tx.sv
// -----------------------------------------------------------------------------
// tb_io_rs232_tx
//   Self-checking bench for io_rs232_tx with BAUD_DIV=4. Expected bytes are
//   queued when a packet is staged; a UART receiver on txd pops and compares
//   every decoded frame. Endpoint RAM is modelled with 2-clk read latency.
// -----------------------------------------------------------------------------
module tb_io_rs232_tx;

  localparam int BD = 4;
`ifdef RS232_TX_CTS_EN
  localparam int START_LAT = 8;  // one extra clk to sample cts at frame start
`else
  localparam int START_LAT = 7;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  buf_out_addr;
  logic [7:0]  buf_out_q;
  logic [9:0]  buf_out_len;
  logic        buf_out_hasdata;
  logic        buf_out_arm;
  logic        buf_out_arm_ack;
  logic        cts;
  logic        txd;
  logic        busy;
  logic [15:0] bytes_sent;

  io_rs232_tx #(.BAUD_DIV(BD), .MAX_LEN(512)) dut (
    .clk             (clk),
    .reset           (reset),
    .buf_out_addr    (buf_out_addr),
    .buf_out_q       (buf_out_q),
    .buf_out_len     (buf_out_len),
    .buf_out_hasdata (buf_out_hasdata),
    .buf_out_arm     (buf_out_arm),
    .buf_out_arm_ack (buf_out_arm_ack),
    .cts             (cts),
    .txd             (txd),
    .busy            (busy),
    .bytes_sent      (bytes_sent)
  );

  always #5 clk = ~clk;

  // Endpoint buffer: registered address, registered data -> 2 clk latency.
  logic [7:0] mem [0:511];
  logic [8:0] ram_a;
  always @(posedge clk) begin
    ram_a     <= buf_out_addr;
    buf_out_q <= mem[ram_a];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Arm pulse observer.
  int arm_cnt = 0;
  int arm_cyc = 0;
  always @(negedge clk) begin
    if (buf_out_arm === 1'b1) begin
      arm_cnt++;
      arm_cyc = cyc;
    end
  end

  // Scoreboard and UART receiver.
  logic [7:0] sb [$];
  int         starts [$];
  int         frames = 0;
  logic       mon_en = 1'b1;

  always begin
    @(negedge clk);
    if (mon_en && txd === 1'b0) begin
      automatic logic [9:0] v = '0;
      automatic logic       stable = 1'b1;
      automatic int         s = cyc;
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < BD; k++) begin
          if (!(b == 0 && k == 0)) @(negedge clk);
          if (k == 0) v[b] = txd;
          else if (txd !== v[b]) stable = 1'b0;
        end
      end
      check("frame_start", v[0], 1'b0);
      check("frame_stop", v[9], 1'b1);
      check("bit_width", stable, 1'b1);
      check("sb_has_entry", sb.size() > 0, 1'b1);
      if (sb.size() > 0) check("frame_data", v[8:1], sb.pop_front());
      starts.push_back(s);
      frames++;
    end
  end

  int exp_bytes = 0;
  int t_hd = 0;

  task automatic start_packet(input int len);
    @(posedge clk); #1;
    buf_out_len     = 10'(len);
    buf_out_hasdata = 1'b1;
    t_hd            = cyc;
  endtask

  // Waits for the arm pulse, retires hasdata, holds off ack for `hold` clk,
  // then acknowledges and checks the block returns to idle.
  task automatic finish_packet(input int hold, input int budget);
    int base;
    base = arm_cnt;
    for (int i = 0; i < budget && arm_cnt == base; i++) @(negedge clk);
    check("arm_seen", arm_cnt - base, 1);
    buf_out_hasdata = 1'b0;
    repeat (hold) @(negedge clk);
    check("arm_wait_busy", busy, 1'b1);
    check("arm_single", arm_cnt - base, 1);
    buf_out_arm_ack = 1'b1;
    repeat (4) @(negedge clk);
    buf_out_arm_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("txd_idle", txd, 1'b1);
    check("bytes_sent", bytes_sent, exp_bytes);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int f0;
    int a0;
    reset           = 1'b1;
    buf_out_len     = '0;
    buf_out_hasdata = 1'b0;
    buf_out_arm_ack = 1'b0;
    cts             = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;

    // 1: reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_arm", buf_out_arm, 1'b0);
    check("rst_addr", buf_out_addr, 9'd0);
    check("rst_bytes", bytes_sent, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // 2: single byte 0x55, start-bit latency
    mem[0] = 8'h55;
    sb.push_back(8'h55);
    starts.delete();
    start_packet(1);
    repeat (10) @(negedge clk);
    check("t2_busy", busy, 1'b1);
    exp_bytes = 1;
    finish_packet(4, 500);
    check("t2_frames", starts.size(), 1);
    if (starts.size() >= 1) check("t2_latency", starts[0] - t_hd, START_LAT);

    // 3: three bytes, inter-frame idle of BD+4 high clk after the data bits
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'hA5;
    sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'hA5);
    starts.delete();
    start_packet(3);
    exp_bytes = 4;
    finish_packet(4, 1000);
    check("t3_frames", starts.size(), 3);
    if (starts.size() >= 3) begin
      check("t3_gap01", starts[1] - starts[0] - 9 * BD, BD + 4);
      check("t3_gap12", starts[2] - starts[1] - 9 * BD, BD + 4);
    end

    // 4: zero-length packet, arm pulse only, held until ack
    f0 = frames;
    start_packet(0);
    finish_packet(30, 200);
    check("t4_arm_time", arm_cyc - t_hd, 4);
    check("t4_no_frame", frames, f0);

    // 5: reset during d3; pending hasdata restarts from address 0
    mon_en = 1'b0;
    mem[0] = 8'h3C; mem[1] = 8'hC3;
    start_packet(2);
    for (int i = 0; i < 200 && txd !== 1'b0; i++) @(negedge clk);
    check("t5_start_seen", txd, 1'b0);
    repeat (4 * BD + 1) @(negedge clk);  // inside d3
    a0 = arm_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_txd", txd, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_addr", buf_out_addr, 9'd0);
    check("t5_rst_bytes", bytes_sent, 16'd0);
    repeat (2) @(negedge clk);
    check("t5_no_arm", arm_cnt, a0);
    @(posedge clk); #1;
    reset = 1'b0;
    t_hd  = cyc;
    mon_en = 1'b1;
    sb.push_back(8'h3C); sb.push_back(8'hC3);
    starts.delete();
    exp_bytes = 2;
    finish_packet(4, 1000);
    check("t5_frames", starts.size(), 2);
    if (starts.size() >= 1) check("t5_latency", starts[0] - t_hd, START_LAT);

`ifdef RS232_TX_CTS_EN
    // 6: cts flow control
    begin
      automatic logic low_seen = 1'b0;
      int t_c;
      cts = 1'b0;
      repeat (4) @(posedge clk);
      mem[0] = 8'h81; mem[1] = 8'h7E;
      sb.push_back(8'h81); sb.push_back(8'h7E);
      starts.delete();
      f0 = frames;
      start_packet(2);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (txd !== 1'b1) low_seen = 1'b1;
      end
      check("t6_cts_hold", low_seen, 1'b0);
      @(posedge clk); #1;
      cts = 1'b1;
      t_c = cyc;
      for (int i = 0; i < 50 && starts.size() == 0; i++) @(negedge clk);
      check("t6_started", starts.size(), 1);
      if (starts.size() >= 1) begin
        check("t6_cts_latency", starts[0] - t_c, 3);
        for (int i = 0; i < 100 && cyc < starts[0] + 5 * BD + 1; i++) @(posedge clk);
        #1;
        cts = 1'b0;  // during d4
      end
      repeat (100) @(negedge clk);
      check("t6_frame1_only", frames, f0 + 1);
      cts = 1'b1;
      exp_bytes = 4;
      finish_packet(4, 500);
      check("t6_frames", frames, f0 + 2);
    end
`endif

    // 7: oversize length clamps to 512 bytes (full 9-bit address range)
    for (int i = 0; i < 512; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      sb.push_back(8'(i) ^ 8'h5A);
    end
    f0 = frames;
    start_packet(1023);
    exp_bytes = exp_bytes + 512;
    finish_packet(4, 30000);
    check("t7_frames", frames - f0, 512);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
